sequenciador_de_ritmo: RTL and testbench

Beat-timing controller for the rhythm game; it drives the pattern manager and judges the player.
- Generates a one-cycle trocar_comando strobe once per beat to advance the pattern manager.
- Opens a hit window at the start of each beat and compares the player's button press with the manager's prox_comando.
- Keeps score and combo, and runs the game state machine: idle, countdown, play, pause, end.

---
 rtl/ritmo_pkg.sv | 22 ++
 rtl/detector_de_borda.sv | 21 ++
 rtl/sequenciador_de_ritmo.sv | 172 +++++++++++++++++
 tb/tb_sequenciador_de_ritmo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ritmo_pkg.sv
// Shared definitions for the rhythm-game beat sequencer: state encodings,
// default timing parameters and datapath widths.
package ritmo_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CONTAGEM = 3'd1,
    JOGANDO  = 3'd2,
    PAUSADO  = 3'd3,
    FIM      = 3'd4
  } estado_t;

  localparam int CICLOS_POR_BATIDA_PADRAO = 12500000;
  localparam int JANELA_PADRAO            = 3125000;
  localparam int CONTAGEM_BATIDAS_PADRAO  = 4;
  localparam int LIMIAR_BONUS_PADRAO      = 8;

  localparam int LARGURA_PONTOS  = 16;
  localparam int LARGURA_COMBO   = 8;
  localparam int LARGURA_COMANDO = 4;

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector: registers the input and flags bits that went 0->1
// relative to the previous cycle.
module detector_de_borda #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_borda
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (reset) r_prev <= '0;
    else       r_prev <= i_x;
  end

  assign o_borda = i_x & ~r_prev;

endmodule

// File: rtl/sequenciador_de_ritmo.sv
// Beat-timing controller: paces the pattern manager, judges button presses
// against the current command inside a hit window and keeps score and combo.
module sequenciador_de_ritmo
  import ritmo_pkg::*;
#(
  parameter int CICLOS_POR_BATIDA = CICLOS_POR_BATIDA_PADRAO,
  parameter int JANELA            = JANELA_PADRAO,
  parameter int CONTAGEM_BATIDAS  = CONTAGEM_BATIDAS_PADRAO,
  parameter int LIMIAR_BONUS      = LIMIAR_BONUS_PADRAO
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       pausar,
  input  logic [LARGURA_COMANDO-1:0] botoes,
  input  logic [LARGURA_COMANDO-1:0] comando_atual,
  input  logic                       fim_de_jogo,
  output logic                       trocar_comando,
  output logic                       jogando,
  output logic [2:0]                 estado,
  output logic [LARGURA_PONTOS-1:0]  pontos,
  output logic [LARGURA_COMBO-1:0]   combo,
  output logic                       acerto,
  output logic                       erro
);

  localparam int LC = (CICLOS_POR_BATIDA > 1) ? $clog2(CICLOS_POR_BATIDA) : 1;
  localparam int LB = (CONTAGEM_BATIDAS > 1) ? $clog2(CONTAGEM_BATIDAS) : 1;
  localparam logic [LC-1:0] ULTIMO_CICLO  = LC'(CICLOS_POR_BATIDA - 1);
  localparam logic [LC-1:0] FIM_JANELA    = LC'(JANELA);
  localparam logic [LB-1:0] ULTIMA_BATIDA = LB'(CONTAGEM_BATIDAS - 1);
  localparam logic [LARGURA_COMBO-1:0] BONUS = LARGURA_COMBO'(LIMIAR_BONUS);

  estado_t                      r_estado;
  logic [LC-1:0]                r_cont;
  logic [LB-1:0]                r_batida;
  logic                         r_julgado;
  logic [LARGURA_PONTOS-1:0]    r_pontos;
  logic [LARGURA_COMBO-1:0]     r_combo;
  logic                         r_acerto;
  logic                         r_erro;

  logic                         w_ini;
  logic                         w_pau;
  logic [LARGURA_COMANDO-1:0]   w_nova;

  detector_de_borda #(.WIDTH(1)) u_borda_iniciar (
    .clk(clk), .reset(reset), .i_x(iniciar), .o_borda(w_ini));
  detector_de_borda #(.WIDTH(1)) u_borda_pausar (
    .clk(clk), .reset(reset), .i_x(pausar), .o_borda(w_pau));
  detector_de_borda #(.WIDTH(LARGURA_COMANDO)) u_borda_botoes (
    .clk(clk), .reset(reset), .i_x(botoes), .o_borda(w_nova));

  logic                         w_jogo_ativo;
  logic                         w_fim_batida;
  logic                         w_certo;
  logic                         w_julgar;
  logic                         w_julgado_pos;
  logic                         w_perdeu;
  logic [1:0]                   w_incr;
  logic [LARGURA_PONTOS:0]      w_soma;
  logic [LARGURA_PONTOS-1:0]    w_pontos_mais;
  logic [LARGURA_COMBO-1:0]     w_combo_mais;

  // A pause edge pre-empts judgement and end-of-beat work in the same cycle.
  assign w_jogo_ativo  = (r_estado == JOGANDO) && !w_pau;
  assign w_fim_batida  = (r_cont == ULTIMO_CICLO);
  assign w_certo       = (r_cont < FIM_JANELA) && (w_nova == comando_atual) && (|comando_atual);
  assign w_julgar      = w_jogo_ativo && (|w_nova) && !r_julgado;
  assign w_julgado_pos = r_julgado | w_julgar;
  assign w_perdeu      = w_jogo_ativo && w_fim_batida && !w_julgado_pos && (|comando_atual);

  assign w_incr        = (r_combo >= BONUS) ? 2'd2 : 2'd1;
  assign w_soma        = {1'b0, r_pontos} + (LARGURA_PONTOS+1)'(w_incr);
  assign w_pontos_mais = w_soma[LARGURA_PONTOS] ? '1 : w_soma[LARGURA_PONTOS-1:0];
  assign w_combo_mais  = (&r_combo) ? r_combo : r_combo + 1'b1;

  // Strobe is combinational so the manager advances on the same edge the
  // beat counter wraps, keeping comando_atual aligned with the new beat.
  always_comb begin
    trocar_comando = 1'b0;
    if (!reset) begin
      if ((r_estado == OCIOSO || r_estado == FIM) && w_ini) trocar_comando = 1'b1;
      if (w_jogo_ativo && w_fim_batida && !fim_de_jogo)     trocar_comando = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_cont    <= '0;
      r_batida  <= '0;
      r_julgado <= 1'b0;
      r_pontos  <= '0;
      r_combo   <= '0;
      r_acerto  <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_acerto <= 1'b0;
      r_erro   <= 1'b0;
      case (r_estado)
        OCIOSO, FIM: begin
          if (w_ini) begin
            r_estado  <= CONTAGEM;
            r_pontos  <= '0;
            r_combo   <= '0;
            r_cont    <= '0;
            r_batida  <= '0;
            r_julgado <= 1'b0;
          end
        end
        CONTAGEM: begin
          if (w_fim_batida) begin
            r_cont <= '0;
            if (r_batida == ULTIMA_BATIDA) begin
              r_estado  <= JOGANDO;
              r_batida  <= '0;
              r_julgado <= 1'b0;
            end else begin
              r_batida <= r_batida + 1'b1;
            end
          end else begin
            r_cont <= r_cont + 1'b1;
          end
        end
        JOGANDO: begin
          if (w_pau) begin
            r_estado <= PAUSADO;
          end else begin
            if (w_julgar) begin
              if (w_certo) begin
                r_acerto <= 1'b1;
                r_combo  <= w_combo_mais;
                r_pontos <= w_pontos_mais;
              end else begin
                r_erro  <= 1'b1;
                r_combo <= '0;
              end
            end
            if (w_perdeu) begin
              r_erro  <= 1'b1;
              r_combo <= '0;
            end
            if (w_fim_batida) begin
              if (fim_de_jogo) begin
                r_estado <= FIM;
              end else begin
                r_cont    <= '0;
                r_julgado <= 1'b0;
              end
            end else begin
              r_cont    <= r_cont + 1'b1;
              r_julgado <= w_julgado_pos;
            end
          end
        end
        PAUSADO: begin
          if (w_pau) r_estado <= JOGANDO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign estado  = r_estado;
  assign jogando = (r_estado == JOGANDO);
  assign pontos  = r_pontos;
  assign combo   = r_combo;
  assign acerto  = r_acerto;
  assign erro    = r_erro;

endmodule

// File: tb/tb_sequenciador_de_ritmo.sv
// Bench for sequenciador_de_ritmo with a short beat (10 cycles, window 4,
// 2 countdown beats, bonus from combo 2) using directed beats.
module tb_sequenciador_de_ritmo;

  localparam int W = 27;

  logic        clk;
  logic        reset;
  logic        iniciar;
  logic        pausar;
  logic [3:0]  botoes;
  logic [3:0]  comando_atual;
  logic        fim_de_jogo;
  logic        trocar_comando;
  logic        jogando;
  logic [2:0]  estado;
  logic [15:0] pontos;
  logic [7:0]  combo;
  logic        acerto;
  logic        erro;

  sequenciador_de_ritmo #(
    .CICLOS_POR_BATIDA(10),
    .JANELA(4),
    .CONTAGEM_BATIDAS(2),
    .LIMIAR_BONUS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iniciar(iniciar),
    .pausar(pausar),
    .botoes(botoes),
    .comando_atual(comando_atual),
    .fim_de_jogo(fim_de_jogo),
    .trocar_comando(trocar_comando),
    .jogando(jogando),
    .estado(estado),
    .pontos(pontos),
    .combo(combo),
    .acerto(acerto),
    .erro(erro)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_pontos = 0;
  int m_combo  = 0;
  logic [W-1:0] exp_q[$];

  // Expected event word: {trocar, acerto, erro, pontos, combo}
  function automatic logic [W-1:0] ev(input logic t, input logic a, input logic e);
    return {t, a, e, 16'(m_pontos), 8'(m_combo)};
  endfunction

  task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_errors++;
      $display("FAIL %s obtido=%0d esperado=%0d t=%0t", nome, obtido, esperado, $time);
    end
  endtask

  // scoreboard monitor: pops one expected event per cycle with any strobe
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] esp;
    if (!reset && (trocar_comando || acerto || erro)) begin
      obs = {trocar_comando, acerto, erro, pontos, combo};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL evento_inesperado obtido=%h esperado=nenhum t=%0t", obs, $time);
      end else begin
        esp = exp_q.pop_front();
        if (obs !== esp) begin
          n_errors++;
          $display("FAIL evento obtido=%h esperado=%h t=%0t", obs, esp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog tempo esgotado t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic julga(input logic [3:0] cmd, input int p, input logic [3:0] v, inout logic julgado);
    if (!julgado) begin
      if (p < 4 && v == cmd && cmd != 4'h0) begin
        m_pontos = m_pontos + ((m_combo >= 2) ? 2 : 1);
        if (m_pontos > 65535) m_pontos = 65535;
        if (m_combo < 255) m_combo = m_combo + 1;
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0));
      end else begin
        m_combo = 0;
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1));
      end
      julgado = 1'b1;
    end
  endtask

  task automatic pausa_e_retoma(input logic [3:0] cmd);
    botoes = 4'h0;
    pausar = 1'b1;
    step();
    pausar = 1'b0;
    chk("estado_pausado", 32'(estado), 32'd3);
    for (int i = 0; i < 50; i++) begin
      botoes  = (i % 2 == 1) ? cmd : 4'h0;
      iniciar = (i == 10);
      step();
    end
    botoes  = 4'h0;
    iniciar = 1'b0;
    chk("pausa_pontos_congelados", 32'(pontos), 32'(m_pontos));
    chk("pausa_combo_congelado", 32'(combo), 32'(m_combo));
    chk("pausa_estado_mantido", 32'(estado), 32'd3);
    pausar = 1'b1;
    step();
    pausar = 1'b0;
    chk("estado_retomado", 32'(estado), 32'd2);
  endtask

  // One beat starting at counter 0; presses p1/p2 (-1 = none) at positions 0..7.
  task automatic joga_batida(input logic [3:0] cmd, input int p1, input logic [3:0] v1,
                             input int p2, input logic [3:0] v2, input logic fim, input int pp);
    logic julgado;
    julgado = 1'b0;
    comando_atual = cmd;
    fim_de_jogo   = fim;
    for (int p = 0; p < 10; p++) begin
      if (p == pp) pausa_e_retoma(cmd);
      botoes = 4'h0;
      if (p == p1) begin botoes = v1; julga(cmd, p, v1, julgado); end
      if (p == p2) begin botoes = v2; julga(cmd, p, v2, julgado); end
      if (p == 9) begin
        if (!fim) exp_q.push_back(ev(1'b1, 1'b0, 1'b0));
        if (!julgado && cmd != 4'h0) begin
          m_combo = 0;
          exp_q.push_back(ev(1'b0, 1'b0, 1'b1));
        end
      end
      @(negedge clk);
      if (p == 8) chk("trocar_antes_do_fim", 32'(trocar_comando), 32'd0);
      if (p == 9) chk("trocar_fim_batida", 32'(trocar_comando), 32'(!fim));
      step();
    end
    botoes      = 4'h0;
    fim_de_jogo = 1'b0;
  endtask

  task automatic inicia_partida();
    iniciar = 1'b1;
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0));
    step();
    iniciar  = 1'b0;
    m_pontos = 0;
    m_combo  = 0;
    chk("estado_contagem", 32'(estado), 32'd1);
    chk("pontos_zerados", 32'(pontos), 32'd0);
    chk("combo_zerado", 32'(combo), 32'd0);
    repeat (19) step();
    chk("contagem_ultimo_ciclo", 32'(estado), 32'd1);
    chk("jogando_na_contagem", 32'(jogando), 32'd0);
    step();
    chk("estado_jogando", 32'(estado), 32'd2);
    chk("jogando_ativo", 32'(jogando), 32'd1);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; pausar = 1'b0;
    botoes = 4'h0; comando_atual = 4'h0; fim_de_jogo = 1'b0;
    repeat (3) step();
    chk("reset_estado", 32'(estado), 32'd0);
    chk("reset_pontos", 32'(pontos), 32'd0);
    chk("reset_combo", 32'(combo), 32'd0);
    chk("reset_jogando", 32'(jogando), 32'd0);
    chk("reset_pulsos", {29'd0, trocar_comando, acerto, erro}, 32'd0);
    reset = 1'b0;
    step();

    inicia_partida();
    chk("pontos_inicio_jogo", 32'(pontos), 32'd0);

    joga_batida(4'h1, 2, 4'h1, -1, 4'h0, 1'b0, -1);
    chk("b1_pontos", 32'(pontos), 32'd1);
    chk("b1_combo", 32'(combo), 32'd1);
    joga_batida(4'h4, 0, 4'h4, 5, 4'h4, 1'b0, -1);
    chk("b2_pontos", 32'(pontos), 32'd2);
    joga_batida(4'h8, 3, 4'h8, -1, 4'h0, 1'b0, -1);
    chk("b3_pontos_bonus", 32'(pontos), 32'd4);
    chk("b3_combo", 32'(combo), 32'd3);
    joga_batida(4'h1, 1, 4'h2, 3, 4'h1, 1'b0, -1);
    chk("b4_combo_erro", 32'(combo), 32'd0);
    chk("b4_pontos_mantidos", 32'(pontos), 32'd4);
    joga_batida(4'h2, 1, 4'h2, -1, 4'h0, 1'b0, -1);
    joga_batida(4'h2, 4, 4'h2, -1, 4'h0, 1'b0, -1);
    chk("limite_janela_combo", 32'(combo), 32'd0);
    joga_batida(4'h3, 6, 4'h3, -1, 4'h0, 1'b0, -1);
    joga_batida(4'h9, 0, 4'h9, -1, 4'h0, 1'b0, -1);
    joga_batida(4'h7, -1, 4'h0, -1, 4'h0, 1'b0, -1);
    chk("perda_combo", 32'(combo), 32'd0);
    chk("perda_pontos", 32'(pontos), 32'd6);
    joga_batida(4'h0, -1, 4'h0, -1, 4'h0, 1'b0, -1);
    joga_batida(4'h0, 1, 4'h1, -1, 4'h0, 1'b0, -1);
    joga_batida(4'h5, 1, 4'h5, -1, 4'h0, 1'b0, 5);
    chk("apos_pausa_pontos", 32'(pontos), 32'd7);
    joga_batida(4'h6, 2, 4'h6, -1, 4'h0, 1'b1, -1);
    chk("fim_estado", 32'(estado), 32'd4);
    chk("fim_jogando", 32'(jogando), 32'd0);
    chk("fim_pontos", 32'(pontos), 32'd8);
    chk("fim_combo", 32'(combo), 32'd2);
    repeat (5) step();
    chk("fim_pontos_mantidos", 32'(pontos), 32'd8);
    chk("fim_estado_mantido", 32'(estado), 32'd4);

    inicia_partida();
    joga_batida(4'h1, 1, 4'h1, -1, 4'h0, 1'b0, -1);
    chk("reinicio_pontos", 32'(pontos), 32'd1);
    chk("reinicio_combo", 32'(combo), 32'd1);
    comando_atual = 4'h2;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("reset_meio_estado", 32'(estado), 32'd0);
    chk("reset_meio_pontos", 32'(pontos), 32'd0);
    chk("reset_meio_combo", 32'(combo), 32'd0);
    chk("reset_meio_pulsos", {29'd0, trocar_comando, acerto, erro}, 32'd0);
    chk("reset_meio_jogando", 32'(jogando), 32'd0);
    reset = 1'b0;
    repeat (5) step();
    chk("fila_vazia", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
